// File: rtl/monster_line_scanner.sv
// Per-frame monster state snapshot, per-line active-list builder and per-pixel
// sprite hit reporter feeding the sprite ROM address and colour mux.
module monster_line_scanner #(
  parameter int MONSTERS     = 12,
  parameter int SPR_W        = 16,
  parameter int SPR_H        = 16,
  parameter int MAX_PER_LINE = 4
) (
  input  logic                     clk_game,
  input  logic                     rst_n,
  input  logic [19*MONSTERS-1:0]   state_monsters,
  input  logic                     frame_start,
  input  logic                     line_start,
  input  logic [7:0]               line_y,
  input  logic                     pix_valid,
  input  logic [7:0]               pix_x,
  output logic                     hit,
  output logic [3:0]               hit_idx,
  output logic [1:0]               hit_dir,
  output logic [3:0]               hit_row,
  output logic [3:0]               hit_col,
  output logic                     scan_busy,
  output logic                     overflow
);

  localparam int CW = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t          state;
  logic [18:0]     snap   [MONSTERS];
  logic [18:0]     shadow [MONSTERS];
  logic            pending;
  logic [7:0]      cur_y;
  logic [3:0]      idx;
  logic [CW-1:0]   count;

  logic [3:0]      l_idx [MAX_PER_LINE];
  logic [1:0]      l_dir [MAX_PER_LINE];
  logic [7:0]      l_x   [MAX_PER_LINE];
  logic [3:0]      l_row [MAX_PER_LINE];

  // Slot currently under examination, selected from the snapshot only.
  logic [18:0]     cur_slot;
  logic            cand;
  logic            last_slot;
  logic [7:0]      row_full;

  always_comb begin
    cur_slot = '0;
    for (int i = 0; i < MONSTERS; i++) begin
      if (idx == 4'(i)) cur_slot = snap[i];
    end
  end

  assign cand      = cur_slot[0] && (cur_y >= cur_slot[18:11]) &&
                     ({1'b0, cur_y} < ({1'b0, cur_slot[18:11]} + 9'(SPR_H)));
  assign last_slot = (idx == 4'(MONSTERS - 1));
  assign row_full  = cur_y - cur_slot[18:11];

  // Horizontal coverage per list entry; the 9-bit bound keeps x near 255 from wrapping.
  logic [MAX_PER_LINE-1:0] ent_match;

  generate
    for (genvar gi = 0; gi < MAX_PER_LINE; gi++) begin : g_match
      assign ent_match[gi] = (CW'(gi) < count) && (pix_x >= l_x[gi]) &&
                             ({1'b0, pix_x} < ({1'b0, l_x[gi]} + 9'(SPR_W)));
    end
  endgenerate

  logic       m_hit;
  logic [3:0] m_idx;
  logic [1:0] m_dir;
  logic [3:0] m_row;
  logic [3:0] m_col;
  logic [7:0] col_full;

  // Descending walk so the lowest matching entry (lowest slot) wins.
  always_comb begin
    m_hit    = 1'b0;
    m_idx    = '0;
    m_dir    = '0;
    m_row    = '0;
    m_col    = '0;
    col_full = '0;
    if (state == READY && pix_valid) begin
      for (int e = MAX_PER_LINE - 1; e >= 0; e--) begin
        if (ent_match[e]) begin
          col_full = pix_x - l_x[e];
          m_hit    = 1'b1;
          m_idx    = l_idx[e];
          m_dir    = l_dir[e];
          m_row    = l_row[e];
          m_col    = col_full[3:0];
        end
      end
    end
  end

  assign scan_busy = (state == SCAN);

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      cur_y    <= '0;
      idx      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      hit      <= 1'b0;
      hit_idx  <= '0;
      hit_dir  <= '0;
      hit_row  <= '0;
      hit_col  <= '0;
      for (int i = 0; i < MONSTERS; i++) begin
        snap[i]   <= '0;
        shadow[i] <= '0;
      end
      for (int e = 0; e < MAX_PER_LINE; e++) begin
        l_idx[e] <= '0;
        l_dir[e] <= '0;
        l_x[e]   <= '0;
        l_row[e] <= '0;
      end
    end else begin
      hit     <= m_hit;
      hit_idx <= m_idx;
      hit_dir <= m_dir;
      hit_row <= m_row;
      hit_col <= m_col;

      if (frame_start && state != SCAN) begin
        for (int i = 0; i < MONSTERS; i++) snap[i] <= state_monsters[i*19 +: 19];
        overflow <= 1'b0;
      end else if (frame_start) begin
        for (int i = 0; i < MONSTERS; i++) shadow[i] <= state_monsters[i*19 +: 19];
        pending <= 1'b1;
      end

      if (line_start) begin
        cur_y <= line_y;
        count <= '0;
        idx   <= '0;
        state <= SCAN;
      end else if (state == SCAN) begin
        if (cand) begin
          if (count < CW'(MAX_PER_LINE)) begin
            for (int e = 0; e < MAX_PER_LINE; e++) begin
              if (CW'(e) == count) begin
                l_idx[e] <= idx;
                l_dir[e] <= cur_slot[2:1];
                l_x[e]   <= cur_slot[10:3];
                l_row[e] <= row_full[3:0];
              end
            end
            count <= count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        if (last_slot) begin
          state <= READY;
          // Deferred snapshot lands as the scan exits; a same-cycle request uses the live bus.
          if (pending || frame_start) begin
            for (int i = 0; i < MONSTERS; i++)
              snap[i] <= frame_start ? state_monsters[i*19 +: 19] : shadow[i];
            pending  <= 1'b0;
            overflow <= 1'b0;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_monster_line_scanner.sv
// Scenario bench for monster_line_scanner: pixel results are queued as
// expectations when driven and compared when the registered outputs appear.
module tb_monster_line_scanner;

  localparam int MONSTERS = 12;

  logic                   clk_game = 1'b0;
  logic                   rst_n = 1'b0;
  logic [19*MONSTERS-1:0] state_monsters = '0;
  logic                   frame_start = 1'b0;
  logic                   line_start = 1'b0;
  logic [7:0]             line_y = '0;
  logic                   pix_valid = 1'b0;
  logic [7:0]             pix_x = '0;
  logic                   hit;
  logic [3:0]             hit_idx;
  logic [1:0]             hit_dir;
  logic [3:0]             hit_row;
  logic [3:0]             hit_col;
  logic                   scan_busy;
  logic                   overflow;

  monster_line_scanner dut (
    .clk_game       (clk_game),
    .rst_n          (rst_n),
    .state_monsters (state_monsters),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .line_y         (line_y),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
    .hit            (hit),
    .hit_idx        (hit_idx),
    .hit_dir        (hit_dir),
    .hit_row        (hit_row),
    .hit_col        (hit_col),
    .scan_busy      (scan_busy),
    .overflow       (overflow)
  );

  always #5 clk_game = ~clk_game;

  typedef struct packed {
    logic       h;
    logic [3:0] idx;
    logic [1:0] dir;
    logic [3:0] row;
    logic [3:0] col;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] sbx_q [$];
  int         checks = 0;
  int         errors = 0;
  logic       exp_due;

  always @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) exp_due <= 1'b0;
    else        exp_due <= pix_valid;
  end

  // Scoreboard: one registered result per pix_valid cycle.
  always @(negedge clk_game) begin
    exp_t       e;
    logic [7:0] px;
    if (exp_due) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: result with no queued expectation");
      end else begin
        e  = sb_q.pop_front();
        px = sbx_q.pop_front();
        if ({hit, hit_idx, hit_dir, hit_row, hit_col} !== e) begin
          errors++;
          $display("FAIL pix x=%0d: got hit=%0b idx=%0d dir=%0d row=%0d col=%0d, want hit=%0b idx=%0d dir=%0d row=%0d col=%0d",
                   px, hit, hit_idx, hit_dir, hit_row, hit_col, e.h, e.idx, e.dir, e.row, e.col);
        end else begin
          $display("pix x=%0d hit=%0b idx=%0d dir=%0d row=%0d col=%0d ok",
                   px, hit, hit_idx, hit_dir, hit_row, hit_col);
        end
      end
    end
  end

  function automatic exp_t hitx(int i, int d, int r, int c);
    exp_t e;
    e.h = 1'b1; e.idx = 4'(i); e.dir = 2'(d); e.row = 4'(r); e.col = 4'(c);
    return e;
  endfunction

  function automatic exp_t miss();
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk_game);
    #1;
  endtask

  task automatic set_slot(input int i, input bit alive, input int dir, input int x, input int y);
    state_monsters[i*19 +: 19] = {8'(y), 8'(x), 2'(dir), alive};
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_line(input int y, output int busy);
    line_start = 1'b1;
    line_y     = 8'(y);
    tick();
    line_start = 1'b0;
    busy = 0;
    for (int k = 0; k < 40 && scan_busy; k++) begin
      busy++;
      tick();
    end
    if (scan_busy) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: scan_busy still 1 after 40 cycles");
    end
    $display("line y=%0d busy_cycles=%0d", y, busy);
  endtask

  task automatic pix(input int x, input exp_t e);
    pix_valid = 1'b1;
    pix_x     = 8'(x);
    sb_q.push_back(e);
    sbx_q.push_back(8'(x));
    tick();
  endtask

  task automatic pix_end();
    pix_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_busy(input string name, input int busy, input int want);
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s: busy cycles %0d, want %0d", name, busy, want);
    end else $display("%s busy cycles %0d ok", name, busy);
  endtask

  task automatic check_ovf(input string name, input logic want);
    checks++;
    if (overflow !== want) begin
      errors++;
      $display("FAIL %s: overflow=%0b, want %0b", name, overflow, want);
    end else $display("%s overflow=%0b ok", name, overflow);
  endtask

  task automatic test_reset();
    checks++;
    if ({hit, hit_idx, hit_dir, hit_row, hit_col, scan_busy, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hit=%0b idx=%0d busy=%0b ovf=%0b, want all 0",
               hit, hit_idx, scan_busy, overflow);
    end else $display("reset outputs all 0 ok");
  endtask

  task automatic test_basic_hit();
    int b;
    state_monsters = '0;
    set_slot(0, 1, 0, 73, 127);
    pulse_frame();
    do_line(130, b);
    check_busy("basic_scan", b, 12);
    pix(75, hitx(0, 0, 3, 2));
    pix(88, hitx(0, 0, 3, 15));
    pix(89, miss());
    pix(72, miss());
    pix_end();
  endtask

  task automatic test_priority();
    int b;
    state_monsters = '0;
    set_slot(3, 1, 2, 91, 105);
    set_slot(7, 1, 1, 91, 105);
    pulse_frame();
    do_line(110, b);
    pix(95, hitx(3, 2, 5, 4));
    pix_end();
    set_slot(3, 0, 2, 91, 105);
    pulse_frame();
    do_line(110, b);
    pix(95, hitx(7, 1, 5, 4));
    pix_end();
  endtask

  task automatic test_overflow();
    int b;
    state_monsters = '0;
    set_slot(0, 1, 1, 0,   105);
    set_slot(2, 1, 1, 40,  105);
    set_slot(4, 1, 1, 80,  105);
    set_slot(6, 1, 3, 120, 105);
    set_slot(8, 1, 1, 200, 105);
    pulse_frame();
    check_ovf("ovf_before", 1'b0);
    do_line(105, b);
    check_ovf("ovf_set", 1'b1);
    pix(3,   hitx(0, 1, 0, 3));
    pix(203, miss());
    pix(125, hitx(6, 3, 0, 5));
    pix_end();
    pulse_frame();
    check_ovf("ovf_cleared", 1'b0);
  endtask

  task automatic test_wrap();
    int b;
    state_monsters = '0;
    set_slot(1, 1, 0, 10, 250);
    pulse_frame();
    do_line(3, b);
    pix(12, miss());
    pix_end();
    set_slot(1, 1, 2, 250, 250);
    pulse_frame();
    do_line(250, b);
    pix(255, hitx(1, 2, 0, 5));
    pix(2,   miss());
    pix(249, miss());
    pix_end();
  endtask

  task automatic test_mid_scan_frame();
    int b;
    state_monsters = '0;
    set_slot(11, 1, 3, 20, 50);
    pulse_frame();
    line_start = 1'b1;
    line_y     = 8'd50;
    tick();
    line_start = 1'b0;
    b = 0;
    for (int k = 0; k < 40; k++) begin
      frame_start = 1'b0;
      if (k == 3) begin
        set_slot(11, 0, 3, 20, 50);
        frame_start = 1'b1;
      end
      if (!scan_busy) break;
      b++;
      tick();
    end
    frame_start = 1'b0;
    check_busy("mid_frame_scan", b, 12);
    pix(25, hitx(11, 3, 0, 5));
    pix_end();
    do_line(50, b);
    check_busy("after_frame_scan", b, 12);
    pix(25, miss());
    pix_end();
  endtask

  task automatic test_reset_mid_scan();
    int b;
    state_monsters = '0;
    set_slot(0, 1, 1, 20, 50);
    pulse_frame();
    do_line(50, b);
    pix(25, hitx(0, 1, 0, 5));
    pix_end();
    line_start = 1'b1;
    line_y     = 8'd50;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scan_busy, hit, overflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_scan: busy=%0b hit=%0b ovf=%0b, want 0 0 0", scan_busy, hit, overflow);
    end else $display("reset mid scan cleared ok");
    tick();
    rst_n = 1'b1;
    tick();
    pix(25, miss());
    pix_end();
    // Snapshot was cleared by reset, so a fresh scan without frame_start finds nothing.
    do_line(50, b);
    pix(25, miss());
    pix_end();
    line_start = 1'b1;
    rst_n      = 1'b0;
    tick();
    line_start = 1'b0;
    rst_n      = 1'b1;
    tick();
    checks++;
    if (scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_on_line_start: scan_busy=%0b, want 0", scan_busy);
    end else $display("reset on line_start no scan ok");
  endtask

  initial begin
    repeat (2) @(posedge clk_game);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic_hit();
    test_priority();
    test_overflow();
    test_wrap();
    test_mid_scan_frame();
    test_reset_mid_scan();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
